// File: rtl/handshake_monitor_n.sv
// handshake_monitor_n: passive monitor for NUM_CH independent valid/ready
// channels. Counts transfers per channel and raises sticky flags when valid
// drops or data changes during a stall, or when a stall lasts MAX_STALL
// cycles. Also records the lowest-indexed channel of the first error event.
// Optional feature macro: HANDSHAKE_MONITOR_N_ASSERT_EN adds per-channel
// concurrent assertions mirroring the three rules; the flags are unaffected.
module handshake_monitor_n #(
  parameter  int NUM_CH    = 4,
  parameter  int DATA_W    = 8,
  parameter  int CNT_W     = 16,
  parameter  int MAX_STALL = 16,
  localparam int CH_IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       clr,
  input  logic [NUM_CH-1:0]          valid,
  input  logic [NUM_CH-1:0]          ready,
  input  logic [NUM_CH*DATA_W-1:0]   data,
  output logic [NUM_CH*CNT_W-1:0]    xfer_count,
  output logic [NUM_CH-1:0]          err_drop,
  output logic [NUM_CH-1:0]          err_data,
  output logic [NUM_CH-1:0]          err_timeout,
  output logic                       err_any,
  output logic                       first_err_valid,
  output logic [CH_IDX_W-1:0]        first_err_ch
);

  // Stall counter only needs to reach MAX_STALL, where it saturates.
  localparam int SC_W = $clog2(MAX_STALL + 1);
  localparam logic [SC_W-1:0]  STALL_MAX = SC_W'(MAX_STALL);
  localparam logic [SC_W-1:0]  STALL_ONE = SC_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}};

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_STALL = 1'b1
  } state_t;

  state_t              r_state     [NUM_CH];
  state_t              w_state_nxt [NUM_CH];
  logic [SC_W-1:0]     r_stall_cnt [NUM_CH];
  logic [SC_W-1:0]     w_stall_nxt [NUM_CH];
  logic [DATA_W-1:0]   r_cap       [NUM_CH];
  logic [DATA_W-1:0]   w_cap_nxt   [NUM_CH];
  logic [CNT_W-1:0]    r_cnt       [NUM_CH];
  logic [CNT_W-1:0]    w_cnt_nxt   [NUM_CH];

  logic [NUM_CH-1:0]   r_err_drop;
  logic [NUM_CH-1:0]   r_err_data;
  logic [NUM_CH-1:0]   r_err_timeout;
  logic                r_first_valid;
  logic [CH_IDX_W-1:0] r_first_ch;

  // Error events detected in the current cycle (before stickiness).
  logic [NUM_CH-1:0]   w_ev_drop;
  logic [NUM_CH-1:0]   w_ev_data;
  logic [NUM_CH-1:0]   w_ev_to;
  logic [NUM_CH-1:0]   w_ev_any;
  logic [NUM_CH-1:0]   w_inc;
  logic                w_first_valid_nxt;
  logic [CH_IDX_W-1:0] w_first_ch_nxt;

  // Per-channel next-state, stall counter, capture and event decode.
  always_comb begin
    w_ev_drop = '0;
    w_ev_data = '0;
    w_ev_to   = '0;
    w_inc     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_state_nxt[i] = r_state[i];
      w_stall_nxt[i] = r_stall_cnt[i];
      w_cap_nxt[i]   = r_cap[i];
      w_cnt_nxt[i]   = r_cnt[i];
      case (r_state[i])
        ST_IDLE: begin
          if (valid[i] && ready[i]) begin
            w_inc[i] = 1'b1;
          end else if (valid[i]) begin
            w_cap_nxt[i]   = data[i*DATA_W +: DATA_W];
            w_stall_nxt[i] = STALL_ONE;
            w_state_nxt[i] = ST_STALL;
            w_ev_to[i]     = (STALL_MAX == STALL_ONE);
          end else begin
            w_state_nxt[i] = ST_IDLE;
          end
        end
        ST_STALL: begin
          if (valid[i]) begin
            w_ev_data[i] = (data[i*DATA_W +: DATA_W] != r_cap[i]);
            if (ready[i]) begin
              w_inc[i]       = 1'b1;
              w_state_nxt[i] = ST_IDLE;
            end else if (r_stall_cnt[i] < STALL_MAX) begin
              w_stall_nxt[i] = r_stall_cnt[i] + STALL_ONE;
              w_ev_to[i]     = ((r_stall_cnt[i] + STALL_ONE) == STALL_MAX);
            end else begin
              w_stall_nxt[i] = STALL_MAX;
            end
          end else begin
            w_ev_drop[i]   = 1'b1;
            w_state_nxt[i] = ST_IDLE;
          end
        end
        default: begin
          w_state_nxt[i] = ST_IDLE;
        end
      endcase
      if (w_inc[i] && (r_cnt[i] != CNT_SAT)) begin
        w_cnt_nxt[i] = r_cnt[i] + CNT_ONE;
      end else begin
        w_cnt_nxt[i] = r_cnt[i];
      end
    end
  end

  // First-error capture: lowest-indexed channel among the first events.
  always_comb begin
    w_ev_any          = w_ev_drop | w_ev_data | w_ev_to;
    w_first_valid_nxt = r_first_valid;
    w_first_ch_nxt    = r_first_ch;
    if (!r_first_valid && (|w_ev_any)) begin
      w_first_valid_nxt = 1'b1;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (w_ev_any[i]) begin
          w_first_ch_nxt = CH_IDX_W'(i);
        end else begin
          w_first_ch_nxt = w_first_ch_nxt;
        end
      end
    end else begin
      w_first_valid_nxt = r_first_valid;
    end
  end

  // State, counters, captured data and sticky flags; RESET beats clr.
  always_ff @(posedge CLK) begin
    if (RESET || clr) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_state[i]     <= ST_IDLE;
        r_stall_cnt[i] <= '0;
        r_cap[i]       <= '0;
        r_cnt[i]       <= '0;
      end
      r_err_drop    <= '0;
      r_err_data    <= '0;
      r_err_timeout <= '0;
      r_first_valid <= 1'b0;
      r_first_ch    <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_state[i]     <= w_state_nxt[i];
        r_stall_cnt[i] <= w_stall_nxt[i];
        r_cap[i]       <= w_cap_nxt[i];
        r_cnt[i]       <= w_cnt_nxt[i];
      end
      r_err_drop    <= r_err_drop | w_ev_drop;
      r_err_data    <= r_err_data | w_ev_data;
      r_err_timeout <= r_err_timeout | w_ev_to;
      r_first_valid <= w_first_valid_nxt;
      r_first_ch    <= w_first_ch_nxt;
    end
  end

  // Pack the per-channel counters onto the output bus.
  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_pack
      assign xfer_count[g*CNT_W +: CNT_W] = r_cnt[g];
    end
  endgenerate

  assign err_drop        = r_err_drop;
  assign err_data        = r_err_data;
  assign err_timeout     = r_err_timeout;
  assign first_err_valid = r_first_valid;
  assign first_err_ch    = r_first_ch;
  assign err_any         = (|r_err_drop) | (|r_err_data) | (|r_err_timeout);

`ifdef HANDSHAKE_MONITOR_N_ASSERT_EN
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_sva
      a_valid_held : assert property (@(posedge CLK) disable iff (RESET)
        (r_state[g] == ST_STALL) |-> valid[g])
        else $error("handshake_monitor_n: valid dropped during stall on channel %0d", g);
      a_data_stable : assert property (@(posedge CLK) disable iff (RESET)
        ((r_state[g] == ST_STALL) && valid[g]) |-> (data[g*DATA_W +: DATA_W] == r_cap[g]))
        else $error("handshake_monitor_n: data changed during stall on channel %0d", g);
      a_stall_short : assert property (@(posedge CLK) disable iff (RESET)
        (r_state[g] == ST_STALL) |-> (r_stall_cnt[g] < STALL_MAX))
        else $error("handshake_monitor_n: stall timeout on channel %0d", g);
    end
  endgenerate
`endif

endmodule

// File: tb/tb_handshake_monitor_n.sv
// Directed bench for handshake_monitor_n: a default-parameter instance plus a
// CNT_W=4 instance sharing the same stimulus for the saturation case.
module tb_handshake_monitor_n;

  logic        CLK;
  logic        RESET;
  logic        clr;
  logic [3:0]  valid;
  logic [3:0]  ready;
  logic [31:0] data;

  logic [63:0] xc16;
  logic [3:0]  drop16, dat16, to16;
  logic        any16, fv16;
  logic [1:0]  fch16;

  logic [15:0] xc4;
  logic [3:0]  drop4, dat4, to4;
  logic        any4, fv4;
  logic [1:0]  fch4;

  int n_checks = 0;
  int n_errors = 0;

  handshake_monitor_n u_dut (
    .CLK(CLK), .RESET(RESET), .clr(clr), .valid(valid), .ready(ready),
    .data(data), .xfer_count(xc16), .err_drop(drop16), .err_data(dat16),
    .err_timeout(to16), .err_any(any16), .first_err_valid(fv16),
    .first_err_ch(fch16)
  );

  handshake_monitor_n #(.CNT_W(4)) u_dut4 (
    .CLK(CLK), .RESET(RESET), .clr(clr), .valid(valid), .ready(ready),
    .data(data), .xfer_count(xc4), .err_drop(drop4), .err_data(dat4),
    .err_timeout(to4), .err_any(any4), .first_err_valid(fv4),
    .first_err_ch(fch4)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic set_data(input int ch, input logic [7:0] v);
    data[ch*8 +: 8] = v;
  endtask

  initial begin
    RESET = 1'b1; clr = 1'b0; valid = 4'h0; ready = 4'h0; data = 32'h0;
    tick(2);
    RESET = 1'b0;
    check_val("rst_count", xc16, 64'h0);
    check_val("rst_err_any", {63'h0, any16}, 64'h0);
    check_val("rst_first_valid", {63'h0, fv16}, 64'h0);
    check_val("rst_flags", {52'h0, drop16, dat16, to16}, 64'h0);

    // Five back-to-back transfers on channel 0.
    valid = 4'b0001; ready = 4'b0001;
    tick(5);
    valid = 4'h0; ready = 4'h0;
    check_val("t1_count0", {48'h0, xc16[15:0]}, 64'd5);
    check_val("t1_count_others", {16'h0, xc16[63:16]}, 64'h0);
    check_val("t1_err_any", {63'h0, any16}, 64'h0);

    // Channel 2 stalls 3 cycles with stable data, then transfers.
    valid = 4'b0100; ready = 4'b0000; set_data(2, 8'hA5);
    tick(3);
    ready = 4'b0100;
    tick(1);
    valid = 4'h0; ready = 4'h0;
    check_val("t2_count2", {48'h0, xc16[47:32]}, 64'd1);
    check_val("t2_err_any", {63'h0, any16}, 64'h0);

    // Ch1 data change and ch3 drop in the same stalled cycle.
    valid = 4'b1010; ready = 4'b0000; set_data(1, 8'h3C); set_data(3, 8'h11);
    tick(2);
    check_val("t3_pre_err_any", {63'h0, any16}, 64'h0);
    set_data(1, 8'h3D); valid = 4'b0010;
    tick(1);
    check_val("t3_err_data", {60'h0, dat16}, 64'b0010);
    check_val("t3_err_drop", {60'h0, drop16}, 64'b1000);
    check_val("t3_first_ch", {62'h0, fch16}, 64'd1);
    check_val("t3_first_valid", {63'h0, fv16}, 64'd1);
    check_val("t3_err_any", {63'h0, any16}, 64'd1);
    ready = 4'b0010;
    tick(1);
    valid = 4'h0; ready = 4'h0;
    check_val("t3_count1_mismatch_xfer", {48'h0, xc16[31:16]}, 64'd1);
    check_val("t3_first_ch_held", {62'h0, fch16}, 64'd1);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    check_val("clr_err_any", {63'h0, any16}, 64'h0);
    check_val("clr_first_valid", {63'h0, fv16}, 64'h0);
    check_val("clr_counts", xc16, 64'h0);

    // Channel 0 timeout after exactly 16 stall cycles.
    valid = 4'b0001; ready = 4'b0000; set_data(0, 8'h77);
    tick(15);
    check_val("t4_to_before", {60'h0, to16}, 64'h0);
    tick(1);
    check_val("t4_to_at16", {60'h0, to16}, 64'b0001);
    check_val("t4_first_ch", {62'h0, fch16}, 64'd0);
    check_val("t4_first_valid", {63'h0, fv16}, 64'd1);
    tick(10);
    check_val("t4_to_after", {60'h0, to16}, 64'b0001);
    check_val("t4_other_flags", {56'h0, drop16, dat16}, 64'h0);
    ready = 4'b0001;
    tick(1);
    valid = 4'h0; ready = 4'h0;
    check_val("t4_count0", {48'h0, xc16[15:0]}, 64'd1);

    // 20 transfers: 4-bit counter saturates, 16-bit one keeps counting.
    valid = 4'b0001; ready = 4'b0001;
    tick(20);
    check_val("t5_sat4", {60'h0, xc4[3:0]}, 64'd15);
    check_val("t5_count16", {48'h0, xc16[15:0]}, 64'd21);
    clr = 1'b1;
    tick(1);
    clr = 1'b0; valid = 4'h0; ready = 4'h0;
    check_val("t5_clr_sat4", {60'h0, xc4[3:0]}, 64'h0);
    check_val("t5_clr_count16", {48'h0, xc16[15:0]}, 64'h0);
    check_val("t5_clr_flags", {51'h0, any16, drop16, dat16, to16}, 64'h0);

    // RESET in the middle of a ch2 stall, then a fresh stall with new data.
    valid = 4'b0100; ready = 4'b0000; set_data(2, 8'h55);
    tick(2);
    RESET = 1'b1;
    tick(1);
    RESET = 1'b0; set_data(2, 8'h66);
    tick(15);
    check_val("t6_no_err", {51'h0, any16, drop16, dat16, to16}, 64'h0);
    tick(1);
    check_val("t6_to_restart", {60'h0, to16}, 64'b0100);
    check_val("t6_no_data_drop", {56'h0, drop16, dat16}, 64'h0);
    valid = 4'h0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/handshake_monitor_n.md
Name: handshake_monitor_n

Overview:
- Parametrised, bind-able protocol monitor for NUM_CH independent valid/ready channels; the generalised successor to the single-handshake RTL monitor.
- Purely observes the channels and drives nothing back into the design.
- Per channel, it counts completed transfers and checks two stability rules: valid must hold, and data must stay unchanged, while stalled.
- Also detects stall timeouts and reports sticky error flags plus the first-offending channel.

Parameters:
- NUM_CH, 4, number of monitored channels (>=1).
- DATA_W, 8, payload width per channel.
- CNT_W, 16, width of each transfer counter.
- MAX_STALL, 16, stall length in cycles at which a timeout is flagged (>=1).
- CH_IDX_W (localparam), max(1, clog2(NUM_CH)), width of the channel index.

Ports:
- CLK  input  1  clock; all logic on posedge.
- RESET  input  1  synchronous, active-high reset.
- clr  input  1  synchronous clear of counters and flags.
- valid  input  NUM_CH  per-channel valid; bit i = channel i.
- ready  input  NUM_CH  per-channel ready.
- data  input  NUM_CH*DATA_W  payloads; channel i occupies bits [i*DATA_W +: DATA_W].
- xfer_count  output  NUM_CH*CNT_W  per-channel transfer count, same packing as data.
- err_drop  output  NUM_CH  sticky: valid deasserted while stalled.
- err_data  output  NUM_CH  sticky: data changed while stalled.
- err_timeout  output  NUM_CH  sticky: stall reached MAX_STALL cycles.
- err_any  output  1  OR of all error flags.
- first_err_valid  output  1  sticky: first_err_ch holds a valid index.
- first_err_ch  output  CH_IDX_W  channel of the earliest error.

Behaviour:
- Reset: on RESET=1 at posedge, all outputs go to 0, every channel enters IDLE, and stall counters and captured data are cleared.
- clr: same effect as RESET, minus any other requirement; clr has priority over any event in the same cycle.
- RESET has priority over clr.
- Per-channel state machine, states IDLE and STALL, evaluated each posedge:
  - IDLE, valid&ready: transfer; xfer_count += 1; stay in IDLE.
  - IDLE, valid&!ready: capture data; stall_cnt = 1; go to STALL.
  - IDLE, !valid: no action.
  - STALL, valid&ready: transfer; count += 1; go to IDLE. If data != captured, set err_data; the transfer is still counted.
  - STALL, valid&!ready: stall_cnt += 1, saturating at MAX_STALL. If data != captured, set err_data; the captured value is not updated.
  - STALL, !valid: set err_drop; go to IDLE; no count.
- Timeout: err_timeout[i] sets on the posedge where stall_cnt transitions to MAX_STALL. With MAX_STALL=1, it sets on the cycle a stall is entered. It fires once per stall episode.
- Counters: xfer_count saturates at 2^CNT_W-1 and does not wrap.
- Flag latency: all flags and counts update at the posedge ending the offending cycle and are visible in the next cycle (1-cycle latency).
- Stickiness: flags remain set until RESET or clr; multiple error types on one channel may all be set.
- First error:
  - When no error has yet been recorded (first_err_valid=0) and one or more channels raise any new error in a cycle, the lowest-indexed such channel is latched into first_err_ch and first_err_valid=1.
  - Later errors do not change first_err_ch.
- err_any is combinational: OR of the registered flags.
- Channels are fully independent; simultaneous activity on all channels is legal.
- Data is compared only while in STALL; data is don't-care when valid=0 in IDLE.

Optional Feature:
- Macro: HANDSHAKE_MONITOR_N_ASSERT_EN.
- Defined:
  - The block additionally contains concurrent SVA assertions on posedge CLK, disabled iff RESET.
  - Per channel, each assertion mirrors one rule: valid held while stalled, data stable while stalled, and stall shorter than MAX_STALL.
  - Each failure issues $error naming the channel index.
  - Flag behaviour is identical.
- Undefined: no assertions or simulation-only constructs; flags only; fully synthesisable.

Test Plan:
- Ch0 valid=ready=1 for 5 cycles while other channels are idle -> xfer_count[0]=5 and all other counts 0 one cycle later; err_any=0.
- Ch2 valid=1, ready=0, data=0xA5 for 3 cycles, then ready=1 -> xfer_count[2]=1, no flags; stall length 3 < 16 so no timeout.
- Ch1 stalls with data 0x3C, then data changes to 0x3D while still stalled; meanwhile ch3 drops valid mid-stall in the same cycle -> err_data[1]=1 and err_drop[3]=1; first_err_ch=1; first_err_valid=1; err_any=1.
- Ch0 valid=1, ready=0 for 16 cycles -> err_timeout[0] set after the 16th stall cycle and not before; staying stalled for 10 more cycles changes nothing further.
- CNT_W=4, 20 back-to-back transfers on ch0 -> xfer_count[0]=15 (saturated); then clr=1 concurrent with a transfer -> count=0 and all flags 0.
- Assert RESET for 1 cycle during a ch2 stall, then resume valid=1, ready=0 with new data -> no err_data or err_drop; the stall restarts from IDLE with stall_cnt=1.
